// File: rtl/control_sequencer.sv
// control_sequencer: micro-step sequencer (T0-T4) for the 8-bit shared-bus CPU.
// Decodes step, opcode and ALU flags into bus-enable and load strobes; at most
// one bus driver is enabled in any cycle.
// Optional feature: define SEQ_EARLY_RESET_EN to return to T0 right after the
// last strobe-carrying step of each instruction instead of idling to T4.
module control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_en,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       pc_out,
  output logic       ram_out,
  output logic       ir_out,
  output logic       a_out,
  output logic       alu_out,
  output logic       mar_load,
  output logic       ram_load,
  output logic       ir_load,
  output logic       a_load,
  output logic       b_load,
  output logic       out_load,
  output logic       pc_load,
  output logic       flags_load,
  output logic       pc_inc,
  output logic       alu_sub,
  output logic       halted,
  output logic [2:0] step
);

  localparam int unsigned StepW = 3;

  typedef enum logic [StepW-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } op_e;

  step_e step_q, step_d;
  logic  halted_q, halted_d;
  logic  active;
  step_e last_step;

  // State register: step counter and sticky halt bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Control word decode and next-state computation.
  always_comb begin
    pc_out     = 1'b0;
    ram_out    = 1'b0;
    ir_out     = 1'b0;
    a_out      = 1'b0;
    alu_out    = 1'b0;
    mar_load   = 1'b0;
    ram_load   = 1'b0;
    ir_load    = 1'b0;
    a_load     = 1'b0;
    b_load     = 1'b0;
    out_load   = 1'b0;
    pc_load    = 1'b0;
    flags_load = 1'b0;
    pc_inc     = 1'b0;
    alu_sub    = 1'b0;
    step_d     = step_q;
    halted_d   = halted_q;
    last_step  = T4;

    active = !reset && step_en && !halted_q;

`ifdef SEQ_EARLY_RESET_EN
    // Last step that carries strobes; the counter wraps right after it.
    case (opcode)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT: last_step = T2;
      OP_LDA, OP_STA:                       last_step = T3;
      OP_ADD, OP_SUB, OP_HLT:               last_step = T4;
      default:                              last_step = T1;
    endcase
`else
    last_step = T4;
`endif

    if (active) begin
      case (step_q)
        T0: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
            OP_LDI: begin
              ir_out = 1'b1;
              a_load = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
            OP_JC: begin
              ir_out  = flag_c;
              pc_load = flag_c;
            end
            OP_JZ: begin
              ir_out  = flag_z;
              pc_load = flag_z;
            end
            OP_OUT: begin
              a_out    = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_load  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              b_load  = 1'b1;
              alu_sub = (opcode == OP_SUB);
            end
            OP_STA: begin
              a_out    = 1'b1;
              ram_load = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out    = 1'b1;
            a_load     = 1'b1;
            flags_load = 1'b1;
            alu_sub    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase

      // HLT freezes the counter at T2; otherwise advance or wrap.
      if (step_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q == last_step || step_q > T4) begin
        step_d = T0;
      end else begin
        step_d = step_e'(StepW'(step_q) + StepW'(1));
      end
    end
  end

  assign halted = halted_q;
  assign step   = StepW'(step_q);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a stimulus process drives inputs and
// pushes the expected control word from a table-driven instruction model; a
// monitor on the falling edge pops and compares.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, step_en, flag_c, flag_z;
  logic [3:0] opcode;
  logic       pc_out, ram_out, ir_out, a_out, alu_out;
  logic       mar_load, ram_load, ir_load, a_load, b_load, out_load, pc_load, flags_load;
  logic       pc_inc, alu_sub, halted;
  logic [2:0] step;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .step_en(step_en), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z),
    .pc_out(pc_out), .ram_out(ram_out), .ir_out(ir_out), .a_out(a_out), .alu_out(alu_out),
    .mar_load(mar_load), .ram_load(ram_load), .ir_load(ir_load), .a_load(a_load),
    .b_load(b_load), .out_load(out_load), .pc_load(pc_load), .flags_load(flags_load),
    .pc_inc(pc_inc), .alu_sub(alu_sub), .halted(halted), .step(step)
  );

  // Strobe bit positions in the expected/observed control word.
  localparam int PCO = 0, RAMO = 1, IRO = 2, AO = 3, ALUO = 4;
  localparam int MARL = 5, RAML = 6, IRL = 7, AL = 8, BL = 9, OUTL = 10;
  localparam int PCL = 11, FLL = 12, PCI = 13, SUBS = 14;

  typedef struct {
    logic [14:0] strobes;
    logic [2:0]  step;
    logic        halted;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   stim_done = 0;

  // Model state: current step and halt bit of the instruction machine.
  int m_step;
  bit m_halted;

  // Micro-program table: exec_tab[op][k] is the word for step T(2+k).
  logic [14:0] exec_tab [16][3];
  int          ins_len  [16];

  function automatic logic [14:0] bits2(int a, int b);
    logic [14:0] w = '0;
    w[a] = 1'b1;
    w[b] = 1'b1;
    return w;
  endfunction

  function automatic logic [14:0] bits3(int a, int b, int c);
    logic [14:0] w = bits2(a, b);
    w[c] = 1'b1;
    return w;
  endfunction

  task automatic build_tables();
    for (int o = 0; o < 16; o++) begin
      for (int k = 0; k < 3; k++) exec_tab[o][k] = '0;
      ins_len[o] = 5;
    end
    exec_tab[1][0] = bits2(IRO, MARL);  exec_tab[1][1] = bits2(RAMO, AL);
    exec_tab[2][0] = bits2(IRO, MARL);  exec_tab[2][1] = bits2(RAMO, BL);
    exec_tab[2][2] = bits3(ALUO, AL, FLL);
    exec_tab[3][0] = bits2(IRO, MARL);  exec_tab[3][1] = bits3(RAMO, BL, SUBS);
    exec_tab[3][2] = bits3(ALUO, AL, FLL) | bits2(SUBS, SUBS);
    exec_tab[4][0] = bits2(IRO, MARL);  exec_tab[4][1] = bits2(AO, RAML);
    exec_tab[5][0] = bits2(IRO, AL);
    exec_tab[6][0] = bits2(IRO, PCL);
    exec_tab[7][0] = bits2(IRO, PCL);
    exec_tab[8][0] = bits2(IRO, PCL);
    exec_tab[14][0] = bits2(AO, OUTL);
`ifdef SEQ_EARLY_RESET_EN
    for (int o = 0; o < 16; o++) ins_len[o] = 2;
    ins_len[5] = 3; ins_len[6] = 3; ins_len[7] = 3; ins_len[8] = 3; ins_len[14] = 3;
    ins_len[1] = 4; ins_len[4] = 4;
    ins_len[2] = 5; ins_len[3] = 5; ins_len[15] = 5;
`endif
  endtask

  function automatic logic [14:0] model_word(bit r, bit en, int op, bit c, bit z);
    if (r || !en || m_halted) return '0;
    if (m_step == 0) return bits2(PCO, MARL);
    if (m_step == 1) return bits3(RAMO, IRL, PCI);
    if (op == 7 && !c) return '0;
    if (op == 8 && !z) return '0;
    return exec_tab[op][m_step-2];
  endfunction

  // One clock of stimulus: drive, predict, advance the model.
  task automatic drive(bit r, bit en, int op, bit c, bit z);
    exp_t e;
    reset = r; step_en = en; opcode = 4'(op); flag_c = c; flag_z = z;
    e.strobes = model_word(r, en, op, c, z);
    e.step    = 3'(m_step);
    e.halted  = m_halted;
    e.cyc     = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      m_step = 0; m_halted = 0;
    end else if (en && !m_halted) begin
      if (m_step == 2 && op == 15) m_halted = 1;
      else if (m_step == ins_len[op] - 1) m_step = 0;
      else m_step = m_step + 1;
    end
    cyc++;
    #1;
  endtask

  task automatic run_instr(int op, bit c, bit z);
    for (int i = 0; i < ins_len[op]; i++) drive(0, 1, op, c, z);
  endtask

  // Monitor: compare every cycle's outputs with the oldest prediction.
  always @(negedge clk) begin
    logic [14:0] obs;
    exp_t        e;
    obs = {alu_sub, pc_inc, flags_load, pc_load, out_load, b_load, a_load,
           ir_load, ram_load, mar_load, alu_out, a_out, ir_out, ram_out, pc_out};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.strobes) begin
        errors++;
        $display("FAIL strobes cyc=%0d op=%h got=%b exp=%b", e.cyc, opcode, obs, e.strobes);
      end
      checks++;
      if (step !== e.step || halted !== e.halted) begin
        errors++;
        $display("FAIL state cyc=%0d got step=%0d halted=%b exp step=%0d halted=%b",
                 e.cyc, step, halted, e.step, e.halted);
      end
      checks++;
      if (!$onehot0({pc_out, ram_out, ir_out, a_out, alu_out})) begin
        errors++;
        $display("FAIL bus_excl cyc=%0d enables=%b exp=onehot0", e.cyc,
                 {pc_out, ram_out, ir_out, a_out, alu_out});
      end
    end
  end

  initial begin
    build_tables();
    m_step = 0; m_halted = 0;
    reset = 1; step_en = 1; opcode = 4'h2; flag_c = 0; flag_z = 0;
    @(posedge clk); #1;

    // Reset held two cycles, then ADD and SUB.
    drive(1, 1, 2, 0, 0);
    drive(1, 1, 2, 0, 0);
    run_instr(2, 0, 0);
    run_instr(3, 1, 1);
    // Conditional jumps, taken and not taken.
    run_instr(7, 1, 0);
    run_instr(7, 0, 1);
    run_instr(8, 0, 1);
    run_instr(8, 1, 0);
    // LDA with a 3-cycle freeze at T2.
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
    for (int i = 2; i < ins_len[1]; i++) drive(0, 1, 1, 0, 0);
    // Every opcode, including the early-wrap sequences.
    for (int o = 0; o < 15; o++) run_instr(o, o[0], o[1]);
    // HLT then 10 idle cycles, then reset.
    for (int i = 0; i < 3; i++) drive(0, 1, 15, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, i % 2, $urandom_range(0, 15), 1, 1);
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      drive(r, $urandom_range(0, 4) != 0, $urandom_range(0, 15),
            1'($urandom), 1'($urandom));
    end

    stim_done = 1;
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
